// File: rtl/t_switch_alloc_pkg.sv
// Shared constants, route encoding and source-mapping helper for the t-switch allocator.
package t_switch_alloc_pkg;

    localparam int unsigned NUM_DIR = 3;
    localparam int unsigned NUM_VC  = 2;
    localparam int unsigned DIR_W   = 2;

    localparam logic [DIR_W-1:0] DIR_L  = 2'd0;
    localparam logic [DIR_W-1:0] DIR_R  = 2'd1;
    localparam logic [DIR_W-1:0] DIR_U0 = 2'd2;

    typedef enum logic [1:0] {
        ROUTE_L   = 2'b00,
        ROUTE_R   = 2'b01,
        ROUTE_U0  = 2'b10,
        ROUTE_ILL = 2'b11
    } t_route_e;

    // Input direction feeding output o through which_dir select s.
    function automatic logic [DIR_W-1:0] src_of(input logic [DIR_W-1:0] o, input logic s);
        case (o)
            DIR_L:   return s ? DIR_U0 : DIR_R;
            DIR_R:   return s ? DIR_U0 : DIR_L;
            default: return s ? DIR_R  : DIR_L;
        endcase
    endfunction

endpackage

// File: rtl/t_switch_alloc_if.sv
// Request/grant/select/credit bundle between the allocator and its surroundings.
interface t_switch_alloc_if;
    import t_switch_alloc_pkg::*;

    logic [NUM_DIR-1:0][NUM_VC-1:0]            in_valid;
    logic [NUM_DIR-1:0][NUM_VC-1:0][DIR_W-1:0] in_route;
    logic [NUM_DIR-1:0][NUM_VC-1:0]            in_grant;
    logic [NUM_DIR-1:0]                        which_vc;
    logic [NUM_DIR-1:0]                        which_dir;
    logic [NUM_DIR-1:0]                        out_valid;
    logic [NUM_DIR-1:0]                        out_vc;
    logic [NUM_DIR-1:0][NUM_VC-1:0]            credit_ret;
    logic                                      err;

    modport slave (
        input  in_valid, in_route, credit_ret,
        output in_grant, which_vc, which_dir, out_valid, out_vc, err
    );

    modport master (
        output in_valid, in_route, credit_ret,
        input  in_grant, which_vc, which_dir, out_valid, out_vc, err
    );

endinterface

// File: rtl/t_switch_alloc_rr_arb2.sv
// Two-requester round-robin arbiter; pointer moves past the winner only when i_upd is set.
module t_switch_alloc_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    output logic [1:0] o_grant_c
);

    logic r_ptr;
    logic w_alt;

    assign w_alt = ~r_ptr;

    always_comb begin : grant_pick
        o_grant_c = 2'b00;
        if (i_req[r_ptr]) begin
            o_grant_c[r_ptr] = 1'b1;
        end else if (i_req[w_alt]) begin
            o_grant_c[w_alt] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : ptr_reg
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_upd) begin
            r_ptr <= ~o_grant_c[1];
        end
    end

endmodule

// File: rtl/t_switch_alloc.sv
// Separable input-first round-robin VC/switch allocator with downstream credit tracking.
module t_switch_alloc
    import t_switch_alloc_pkg::*;
#(
    parameter int unsigned CREDITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    t_switch_alloc_if.slave   bus
);

    localparam int unsigned      CNT_W    = $clog2(CREDITS + 1);
    localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

    logic                                       r_run;
    logic                                       r_err;
    logic [NUM_DIR-1:0][NUM_VC-1:0][CNT_W-1:0]  r_credit;
    logic [NUM_DIR-1:0][NUM_VC-1:0][CNT_W-1:0]  w_credit_nxt;
    logic                                       w_ovf;
    logic                                       w_err_set;
    logic [NUM_VC-1:0][3:0]                     w_cok;
    logic [NUM_DIR-1:0][NUM_VC-1:0]             w_valid;
    logic [NUM_DIR-1:0][NUM_VC-1:0]             w_elig;
    logic [NUM_DIR-1:0][NUM_VC-1:0]             w_s1_gnt;
    logic [NUM_DIR-1:0][NUM_VC-1:0]             w_grant;
    logic [NUM_DIR-1:0]                         w_pick;
    logic [NUM_DIR-1:0]                         w_pick_vc;
    logic [NUM_DIR-1:0][DIR_W-1:0]              w_pick_route;
    logic [NUM_DIR-1:0]                         w_ip_upd;
    logic [NUM_DIR-1:0][1:0]                    w_s2_req;
    logic [NUM_DIR-1:0][1:0]                    w_s2_gnt;
    logic [NUM_DIR-1:0]                         w_out_valid;
    logic [NUM_DIR-1:0]                         w_out_vc;
    logic [NUM_DIR-1:0]                         w_out_dir;

    // Credit availability per VC, indexed by route code (code 3 never has credit).
    always_comb begin : credit_ok
        w_cok = '0;
        for (int v = 0; v < 2; v++) begin
            for (int o = 0; o < 3; o++) begin
                w_cok[v][o] = (r_credit[o][v] != '0);
            end
        end
    end

    // Requests are ignored until the first edge after reset release.
    always_comb begin : eligibility
        w_valid   = '0;
        w_elig    = '0;
        w_err_set = 1'b0;
        for (int d = 0; d < 3; d++) begin
            for (int v = 0; v < 2; v++) begin
                w_valid[d][v] = bus.in_valid[d][v] & r_run;
                if (w_valid[d][v]) begin
                    if (bus.in_route[d][v] == ROUTE_ILL || bus.in_route[d][v] == 2'(d)) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_elig[d][v] = w_cok[v][bus.in_route[d][v]];
                    end
                end
            end
        end
    end

    for (genvar d = 0; d < 3; d++) begin : g_in
        t_switch_alloc_rr_arb2 u_vc_arb (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_req     (w_elig[d]),
            .i_upd     (w_ip_upd[d]),
            .o_grant_c (w_s1_gnt[d])
        );
        assign w_pick[d]       = |w_s1_gnt[d];
        assign w_pick_vc[d]    = w_s1_gnt[d][1];
        assign w_pick_route[d] = bus.in_route[d][w_s1_gnt[d][1]];
        assign w_ip_upd[d]     = |w_grant[d];
    end

    for (genvar o = 0; o < 3; o++) begin : g_out
        localparam logic [DIR_W-1:0] S0 = src_of(2'(o), 1'b0);
        localparam logic [DIR_W-1:0] S1 = src_of(2'(o), 1'b1);

        assign w_s2_req[o] = {w_pick[S1] && (w_pick_route[S1] == 2'(o)),
                              w_pick[S0] && (w_pick_route[S0] == 2'(o))};

        t_switch_alloc_rr_arb2 u_src_arb (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_req     (w_s2_req[o]),
            .i_upd     (w_out_valid[o]),
            .o_grant_c (w_s2_gnt[o])
        );

        assign w_out_valid[o] = |w_s2_gnt[o];
        assign w_out_dir[o]   = w_s2_gnt[o][1];
        assign w_out_vc[o]    = w_s2_gnt[o][1] ? w_pick_vc[S1] : (w_s2_gnt[o][0] & w_pick_vc[S0]);
    end

    // Map each stage-2 winner back to its (input, VC) pop.
    always_comb begin : grant_map
        w_grant = '0;
        for (int o = 0; o < 3; o++) begin
            for (int s = 0; s < 2; s++) begin
                if (w_s2_gnt[o][s]) begin
                    w_grant[src_of(2'(o), 1'(s))][w_pick_vc[src_of(2'(o), 1'(s))]] = 1'b1;
                end
            end
        end
    end

    always_comb begin : credit_next
        w_credit_nxt = r_credit;
        w_ovf        = 1'b0;
        for (int o = 0; o < 3; o++) begin
            for (int v = 0; v < 2; v++) begin
                if ((w_out_valid[o] && (w_out_vc[o] == 1'(v))) && !bus.credit_ret[o][v]) begin
                    w_credit_nxt[o][v] = r_credit[o][v] - CNT_W'(1);
                end else if (bus.credit_ret[o][v] && !(w_out_valid[o] && (w_out_vc[o] == 1'(v)))) begin
                    if (r_credit[o][v] == CRED_MAX) begin
                        w_ovf = 1'b1;
                    end else begin
                        w_credit_nxt[o][v] = r_credit[o][v] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            r_run    <= 1'b0;
            r_err    <= 1'b0;
            r_credit <= {(NUM_DIR*NUM_VC){CRED_MAX}};
        end else begin
            r_run    <= 1'b1;
            r_credit <= w_credit_nxt;
            if (w_err_set || w_ovf) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.in_grant  = w_grant;
    assign bus.which_vc  = w_pick_vc;
    assign bus.which_dir = w_out_dir;
    assign bus.out_valid = w_out_valid;
    assign bus.out_vc    = w_out_vc;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_t_switch_alloc.sv
// Directed scoreboard bench for the t-switch allocator.
module tb_t_switch_alloc;
    import t_switch_alloc_pkg::*;

    logic clk;
    logic rst_n;

    t_switch_alloc_if bus();

    t_switch_alloc #(.CREDITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] gnt;
        logic [2:0] wvc;
        logic [2:0] wdir;
        logic [2:0] oval;
        logic [2:0] ovc;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input logic [5:0] g, input logic [2:0] wvc, input logic [2:0] wdir,
                                input logic [2:0] oval, input logic [2:0] ovc, input logic e);
        exp_t r;
        r.gnt = g; r.wvc = wvc; r.wdir = wdir; r.oval = oval; r.ovc = ovc; r.err = e;
        return r;
    endfunction

    task automatic check(input string tag);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty obs=0 exp=1", tag);
            return;
        end
        e = q.pop_front();
        assert (bus.in_grant === e.gnt) else begin
            errors++; $error("FAIL %s in_grant obs=%b exp=%b", tag, bus.in_grant, e.gnt);
        end
        checks++;
        assert (bus.which_vc === e.wvc) else begin
            errors++; $error("FAIL %s which_vc obs=%b exp=%b", tag, bus.which_vc, e.wvc);
        end
        checks++;
        assert (bus.which_dir === e.wdir) else begin
            errors++; $error("FAIL %s which_dir obs=%b exp=%b", tag, bus.which_dir, e.wdir);
        end
        checks++;
        assert (bus.out_valid === e.oval) else begin
            errors++; $error("FAIL %s out_valid obs=%b exp=%b", tag, bus.out_valid, e.oval);
        end
        checks++;
        assert (bus.out_vc === e.ovc) else begin
            errors++; $error("FAIL %s out_vc obs=%b exp=%b", tag, bus.out_vc, e.ovc);
        end
        checks++;
        assert (bus.err === e.err) else begin
            errors++; $error("FAIL %s err obs=%b exp=%b", tag, bus.err, e.err);
        end
    endtask

    task automatic idle();
        bus.in_valid   = '0;
        bus.in_route   = '0;
        bus.credit_ret = '0;
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic step(input exp_t e, input string tag);
        q.push_back(e);
        #2;
        check(tag);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    exp_t zero;
    exp_t exp_a;

    initial begin
        zero  = mk(6'b0, 3'b0, 3'b0, 3'b0, 3'b0, 1'b0);
        exp_a = mk(6'b000101, 3'b000, 3'b100, 3'b110, 3'b000, 1'b0);

        // Requests present while in reset must produce nothing.
        rst_n           = 1'b0;
        bus.in_valid    = '1;
        bus.credit_ret  = '0;
        bus.in_route[0] = {ROUTE_R, ROUTE_R};
        bus.in_route[1] = {ROUTE_L, ROUTE_L};
        bus.in_route[2] = {ROUTE_L, ROUTE_L};
        @(negedge clk);
        step(zero, "reset_outputs");

        // Single flit l VC0 -> r, then drain r VC0 credits to zero.
        do_reset();
        bus.in_valid[0][0] = 1'b1;
        bus.in_route[0][0] = ROUTE_R;
        for (int i = 0; i < 4; i++) step(mk(6'b000001, 3'b000, 3'b000, 3'b010, 3'b000, 1'b0), "single_flit");
        step(zero, "single_no_credit");

        // Output contention l/u0 VC1 -> r alternates by source pointer.
        do_reset();
        bus.in_valid[0][1] = 1'b1; bus.in_route[0][1] = ROUTE_R;
        bus.in_valid[2][1] = 1'b1; bus.in_route[2][1] = ROUTE_R;
        for (int i = 0; i < 2; i++) begin
            step(mk(6'b000010, 3'b101, 3'b000, 3'b010, 3'b010, 1'b0), "contend_l");
            step(mk(6'b100000, 3'b101, 3'b010, 3'b010, 3'b010, 1'b0), "contend_u0");
        end
        step(zero, "contend_exhausted");

        // VC fairness on r -> u0 with matching credit return each cycle.
        do_reset();
        bus.in_valid[1] = 2'b11;
        bus.in_route[1] = {ROUTE_U0, ROUTE_U0};
        for (int i = 0; i < 2; i++) begin
            bus.credit_ret = '0; bus.credit_ret[2][0] = 1'b1;
            step(mk(6'b000100, 3'b000, 3'b100, 3'b100, 3'b000, 1'b0), "fair_vc0");
            bus.credit_ret = '0; bus.credit_ret[2][1] = 1'b1;
            step(mk(6'b001000, 3'b010, 3'b100, 3'b100, 3'b100, 1'b0), "fair_vc1");
        end
        idle();
        bus.credit_ret[2][0] = 1'b1;
        step(zero, "overflow_pulse");
        idle();
        step(mk(6'b0, 3'b0, 3'b0, 3'b0, 3'b0, 1'b1), "overflow_err");

        // Credit stall on l VC0 and release by credit return.
        do_reset();
        bus.in_valid[1][0] = 1'b1;
        bus.in_route[1][0] = ROUTE_L;
        for (int i = 0; i < 4; i++) step(mk(6'b000100, 3'b000, 3'b000, 3'b001, 3'b000, 1'b0), "stall_drain");
        step(zero, "stall_blocked");
        bus.credit_ret[0][0] = 1'b1;
        step(zero, "stall_return");
        step(mk(6'b000100, 3'b000, 3'b000, 3'b001, 3'b000, 1'b0), "stall_grant_and_ret");
        bus.credit_ret = '0;
        step(mk(6'b000100, 3'b000, 3'b000, 3'b001, 3'b000, 1'b0), "stall_last_credit");
        step(zero, "stall_blocked_again");

        // Illegal routes flag err, never granted, do not block the other VC.
        do_reset();
        bus.in_valid[2] = 2'b11;
        bus.in_route[2][0] = ROUTE_U0;
        bus.in_route[2][1] = ROUTE_L;
        step(mk(6'b100000, 3'b100, 3'b001, 3'b001, 3'b001, 1'b0), "err_other_vc");
        step(mk(6'b100000, 3'b100, 3'b001, 3'b001, 3'b001, 1'b1), "err_set");
        idle();
        bus.in_valid[0][0] = 1'b1;
        bus.in_route[0][0] = ROUTE_ILL;
        step(mk(6'b0, 3'b0, 3'b0, 3'b0, 3'b0, 1'b1), "err_route11");
        idle();
        for (int i = 0; i < 2; i++) step(mk(6'b0, 3'b0, 3'b0, 3'b0, 3'b0, 1'b1), "err_sticky");

        // Asynchronous reset mid-traffic clears outputs and pointers at once.
        do_reset();
        bus.in_valid[0][0] = 1'b1; bus.in_route[0][0] = ROUTE_R;
        bus.in_valid[1]    = 2'b11; bus.in_route[1] = {ROUTE_U0, ROUTE_U0};
        step(exp_a, "areset_pre");
        #3;
        rst_n = 1'b0;
        #1;
        q.push_back(zero);
        check("areset_immediate");
        @(negedge clk);
        rst_n = 1'b1;
        step(zero, "areset_release");
        step(exp_a, "areset_first_grant");

        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
